// File: rtl/geared_stream_distribute_pkg.sv
// Shared types and helpers for the geared stream distributor.
// rr_first picks one requester, searching upward from a start index and wrapping.
package memory_island_gear_pkg;

    typedef enum logic {GEAR_STRICT, GEAR_FIRST_FREE} gear_mode_e;

    localparam int GEAR_MAX_LANES = 64;
    localparam int GEAR_IDX_W     = 6;

    // Returns a one-hot grant (or zero). Only the low n bits of req are searched.
    function automatic logic [GEAR_MAX_LANES-1:0] rr_first(
        input logic [GEAR_MAX_LANES-1:0] req,
        input int unsigned               start,
        input int unsigned               n
    );
        logic [GEAR_MAX_LANES-1:0] grant;
        logic                      found;
        int unsigned               idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < GEAR_MAX_LANES; k++) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[GEAR_IDX_W-1:0]]) begin
                grant[idx[GEAR_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/geared_stream_distribute_lane_fifo.sv
// Per-lane in-order FIFO with registered output (no fall-through) and occupancy count.
// data_o reads as zero whenever the lane is empty.
module geared_lane_fifo #(
    parameter int  Depth = 1,
    parameter type T     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output T                           data_o,
    output logic [$clog2(Depth+1)-1:0] fill_o
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int FW = $clog2(Depth + 1);

    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "geared_lane_fifo: Depth must be >= 1");
    end

    T              r_mem [Depth];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [FW-1:0] r_fill;

    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_fill <= '0;
        end else begin
            if (push_i) r_wr <= f_next(r_wr);
            if (pop_i)  r_rd <= f_next(r_rd);
            case ({push_i, pop_i})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign full_o  = (r_fill == FW'(Depth));
    assign empty_o = (r_fill == '0);
    assign fill_o  = r_fill;

    always_comb begin
        if (empty_o) data_o = '0;
        else         data_o = r_mem[r_rd];
    end

endmodule

// File: rtl/geared_stream_distribute.sv
// Spreads one fast valid/ready stream across GearRatio lane FIFOs feeding slow consumers;
// a free-running slot counter names the lane that owns each fast cycle.
module geared_stream_distribute
    import memory_island_gear_pkg::*;
#(
    parameter int         GearRatio = 2,
    parameter int         Depth     = 1,
    parameter gear_mode_e Mode      = GEAR_STRICT,
    parameter type        T         = logic
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      clr_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  T                                          data_i,
    output logic [GearRatio-1:0]                      slot_o,
    output logic [GearRatio-1:0]                      lane_sel_o,
    output logic [GearRatio-1:0]                      valid_o,
    input  logic [GearRatio-1:0]                      ready_i,
    output T     [GearRatio-1:0]                      data_o,
    output logic [GearRatio-1:0][$clog2(Depth+1)-1:0] lane_fill_o
);
    localparam int SW = (GearRatio > 1) ? $clog2(GearRatio) : 1;

    if (GearRatio < 1) begin : g_bad_gear
        $fatal(1, "geared_stream_distribute: GearRatio must be >= 1");
    end
    if (GearRatio > GEAR_MAX_LANES) begin : g_big_gear
        $fatal(1, "geared_stream_distribute: GearRatio exceeds GEAR_MAX_LANES");
    end
    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "geared_stream_distribute: Depth must be >= 1");
    end

    logic [SW-1:0]        w_slot_idx;
    logic [GearRatio-1:0] w_full;
    logic [GearRatio-1:0] w_empty;
    logic [GearRatio-1:0] w_space;
    logic [GearRatio-1:0] w_pop;
    logic [GearRatio-1:0] w_push;

    // Slot ownership advances every cycle, independent of any handshake.
    if (GearRatio > 1) begin : g_slot_cnt
        logic [SW-1:0] r_slot;
        always_ff @(posedge clk_i) begin
            if (rst_i || clr_i)                     r_slot <= '0;
            else if (r_slot == SW'(GearRatio - 1)) r_slot <= '0;
            else                                    r_slot <= r_slot + 1'b1;
        end
        assign w_slot_idx = r_slot;
    end else begin : g_slot_fixed
        assign w_slot_idx = '0;
    end

    assign slot_o  = GearRatio'(1) << w_slot_idx;
    assign valid_o = ~w_empty;
    assign w_pop   = valid_o & ready_i;
    // A full lane that is draining this cycle can still take a beat.
    assign w_space = ~w_full | w_pop;
    assign w_push  = lane_sel_o & {GearRatio{valid_i}};
    assign ready_o = |lane_sel_o;

    if (Mode == GEAR_FIRST_FREE) begin : g_first_free
        logic [GEAR_MAX_LANES-1:0] w_req;
        always_comb begin
            w_req                = '0;
            w_req[GearRatio-1:0] = w_space;
        end
        assign lane_sel_o = GearRatio'(rr_first(w_req, 32'(w_slot_idx), GearRatio));
    end else begin : g_strict
        assign lane_sel_o = slot_o & w_space;
    end

    for (genvar g = 0; g < GearRatio; g++) begin : g_lane
        geared_lane_fifo #(
            .Depth (Depth),
            .T     (T)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr_i),
            .push_i  (w_push[g]),
            .data_i  (data_i),
            .pop_i   (w_pop[g]),
            .full_o  (w_full[g]),
            .empty_o (w_empty[g]),
            .data_o  (data_o[g]),
            .fill_o  (lane_fill_o[g])
        );
    end

endmodule

// File: tb/tb_geared_stream_distribute.sv
// Bench for geared_stream_distribute: a GearRatio=1 vector table, directed corner sequences,
// and random traffic on three GearRatio=4 configurations checked against a queue-based model.
module tb_geared_stream_distribute;
    import memory_island_gear_pkg::*;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // GearRatio=4 instances share stimulus: 0 STRICT D1, 1 STRICT D2, 2 FIRST_FREE D1
    logic       rst = 1'b1, clr = 1'b0, valid = 1'b0;
    byte_t      data = '0;
    logic [3:0] rdy_in = '0;

    logic        rdy_w  [3];
    logic [3:0]  slot_w [3];
    logic [3:0]  sel_w  [3];
    logic [3:0]  vld_w  [3];
    byte_t [3:0] data_w [3];
    logic [3:0][0:0] fill_a, fill_c;
    logic [3:0][1:0] fill_b;

    geared_stream_distribute #(.GearRatio(4), .Depth(1), .Mode(GEAR_STRICT), .T(byte_t)) u_s41 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(valid), .ready_o(rdy_w[0]), .data_i(data),
        .slot_o(slot_w[0]), .lane_sel_o(sel_w[0]), .valid_o(vld_w[0]), .ready_i(rdy_in),
        .data_o(data_w[0]), .lane_fill_o(fill_a));

    geared_stream_distribute #(.GearRatio(4), .Depth(2), .Mode(GEAR_STRICT), .T(byte_t)) u_s42 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(valid), .ready_o(rdy_w[1]), .data_i(data),
        .slot_o(slot_w[1]), .lane_sel_o(sel_w[1]), .valid_o(vld_w[1]), .ready_i(rdy_in),
        .data_o(data_w[1]), .lane_fill_o(fill_b));

    geared_stream_distribute #(.GearRatio(4), .Depth(1), .Mode(GEAR_FIRST_FREE), .T(byte_t)) u_f41 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(valid), .ready_o(rdy_w[2]), .data_i(data),
        .slot_o(slot_w[2]), .lane_sel_o(sel_w[2]), .valid_o(vld_w[2]), .ready_i(rdy_in),
        .data_o(data_w[2]), .lane_fill_o(fill_c));

    // GearRatio=1, Depth=3: a plain FIFO
    logic        g_rst = 1'b1, g_clr = 1'b0, g_valid = 1'b0, g_rdy = 1'b0;
    byte_t       g_data = '0;
    logic        g_rdy_o;
    logic [0:0]  g_slot, g_sel, g_vld;
    byte_t [0:0] g_dout;
    logic [0:0][1:0] g_fill;

    geared_stream_distribute #(.GearRatio(1), .Depth(3), .Mode(GEAR_STRICT), .T(byte_t)) u_g13 (
        .clk_i(clk), .rst_i(g_rst), .clr_i(g_clr), .valid_i(g_valid), .ready_o(g_rdy_o),
        .data_i(g_data), .slot_o(g_slot), .lane_sel_o(g_sel), .valid_o(g_vld), .ready_i(g_rdy),
        .data_o(g_dout), .lane_fill_o(g_fill));

    // Reference model: per-lane queues, slot = cycles since reset mod 4
    byte_t      mq [3][4][$];
    int         mdepth [3] = '{1, 2, 1};
    bit         mff    [3] = '{1'b0, 1'b0, 1'b1};
    int         mcyc = 0;
    logic [3:0] msel [3];

    function automatic logic [3:0] model_sel(int m);
        int         s;
        int         i;
        bit         found;
        logic [3:0] sp;
        logic [3:0] r;
        s = mcyc % 4;
        r = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++)
            sp[k] = (mq[m][k].size() < mdepth[m]) || (mq[m][k].size() > 0 && rdy_in[k]);
        if (!mff[m]) begin
            if (sp[s]) r[s] = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                i = (s + k) % 4;
                if (!found && sp[i]) begin
                    r[i] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] act_fill(int m, int i);
        case (m)
            0:       return 32'(fill_a[i]);
            1:       return 32'(fill_b[i]);
            default: return 32'(fill_c[i]);
        endcase
    endfunction

    function automatic void check_dut(int m);
        msel[m] = model_sel(m);
        chk($sformatf("d%0d slot", m), 32'(slot_w[m]), 32'(1) << (mcyc % 4));
        chk($sformatf("d%0d lane_sel", m), 32'(sel_w[m]), 32'(msel[m]));
        chk($sformatf("d%0d ready_o", m), 32'(rdy_w[m]), 32'(msel[m] != 4'b0000));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d%0d valid_o[%0d]", m, i), 32'(vld_w[m][i]), 32'(mq[m][i].size() > 0));
            chk($sformatf("d%0d data_o[%0d]", m, i), 32'(data_w[m][i]),
                (mq[m][i].size() > 0) ? 32'(mq[m][i][0]) : 32'(0));
            chk($sformatf("d%0d fill[%0d]", m, i), act_fill(m, i), 32'(mq[m][i].size()));
        end
    endfunction

    function automatic void model_update();
        if (rst || clr) begin
            for (int m = 0; m < 3; m++)
                for (int i = 0; i < 4; i++) mq[m][i].delete();
            mcyc = 0;
        end else begin
            for (int m = 0; m < 3; m++)
                for (int i = 0; i < 4; i++) begin
                    if (mq[m][i].size() > 0 && rdy_in[i]) void'(mq[m][i].pop_front());
                    if (valid && msel[m][i]) mq[m][i].push_back(data);
                end
            mcyc++;
        end
    endfunction

    task automatic step_check();
        @(negedge clk);
        for (int m = 0; m < 3; m++) check_dut(m);
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        step_check();
        step_clk();
    endtask

    typedef struct {
        logic  v;
        byte_t d;
        logic  r;
        logic  e_rdy;
        logic  e_vld;
        byte_t e_dat;
        int    e_fill;
    } g_vec_t;

    g_vec_t gv [15];

    initial begin
        gv[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        gv[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h10, 1};
        gv[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h10, 2};
        gv[3]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h10, 3};
        gv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 3};
        gv[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2};
        gv[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1};
        gv[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        gv[8]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        gv[9]  = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 8'h20, 1};
        gv[10] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h20, 2};
        gv[11] = '{1'b1, 8'h23, 1'b1, 1'b1, 1'b1, 8'h20, 3};
        gv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h21, 3};
        gv[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h21, 3};
        gv[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 2};

        // GearRatio=1 table while the GearRatio=4 instances sit in reset
        repeat (2) @(posedge clk);
        #1;
        g_rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            g_valid = gv[n].v;
            g_data  = gv[n].d;
            g_rdy   = gv[n].r;
            @(negedge clk);
            chk($sformatf("g1 row%0d slot", n), 32'(g_slot), 32'(1));
            chk($sformatf("g1 row%0d ready_o", n), 32'(g_rdy_o), 32'(gv[n].e_rdy));
            chk($sformatf("g1 row%0d lane_sel", n), 32'(g_sel), 32'(gv[n].e_rdy));
            chk($sformatf("g1 row%0d valid_o", n), 32'(g_vld), 32'(gv[n].e_vld));
            chk($sformatf("g1 row%0d data_o", n), 32'(g_dout[0]), 32'(gv[n].e_dat));
            chk($sformatf("g1 row%0d fill", n), 32'(g_fill[0]), 32'(gv[n].e_fill));
            @(posedge clk);
            #1;
        end
        g_valid = 1'b0;
        g_rdy   = 1'b0;
        g_clr   = 1'b1;
        @(posedge clk);
        #1;
        g_clr = 1'b0;
        @(negedge clk);
        chk("g1 clr valid_o", 32'(g_vld), 32'(0));
        chk("g1 clr fill", 32'(g_fill[0]), 32'(0));
        chk("g1 clr data_o", 32'(g_dout[0]), 32'(0));

        // GearRatio=4: reset, then full-rate strict traffic
        @(posedge clk);
        #1;
        rst = 1'b1;
        step_clk();
        step_clk();
        rst    = 1'b0;
        rdy_in = 4'b1111;
        valid  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            data = byte_t'(c);
            step_check();
            if (c == 0) begin
                chk("reset slot_o", 32'(slot_w[1]), 32'(4'b0001));
                chk("reset valid_o", 32'(vld_w[1]), 32'(0));
                chk("reset fill", 32'(fill_b), 32'(0));
            end else begin
                chk($sformatf("fullrate lane%0d data", (c - 1) % 4), 32'(data_w[0][(c - 1) % 4]), 32'(c - 1));
            end
            chk("fullrate ready_o", 32'(rdy_w[0]), 32'(1));
            step_clk();
        end

        // Lane 2 stalled: Depth=2 lane takes two beats, then refuses its slot
        rdy_in = 4'b1011;
        for (int c = 12; c < 32; c++) begin
            data = byte_t'(c);
            step_check();
            if (c % 4 != 2)   chk("stall other-slot ready_o", 32'(rdy_w[1]), 32'(1));
            else if (c >= 22) chk("stall slot2 ready_o", 32'(rdy_w[1]), 32'(0));
            step_clk();
        end
        chk("stall lane2 fill", 32'(fill_b[2]), 32'(2));

        // Pile up beats everywhere, then reset mid-stream
        rdy_in = 4'b0000;
        for (int c = 32; c < 36; c++) begin
            data = byte_t'(c);
            tick();
        end
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        rst = 1'b0;

        // FIRST_FREE bypass: lanes 0 and 1 full and stalled at slot 0
        valid = 1'b1;
        data  = 8'hA0;
        step_check();
        chk("midrst valid_o", 32'(vld_w[1]), 32'(0));
        chk("midrst fill", 32'(fill_b), 32'(0));
        chk("midrst slot_o", 32'(slot_w[1]), 32'(4'b0001));
        step_clk();
        data = 8'hA1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        valid = 1'b1;
        data  = 8'hA4;
        step_check();
        chk("ff bypass lane_sel", 32'(sel_w[2]), 32'(4'b0100));
        chk("strict blocked lane_sel", 32'(sel_w[0]), 32'(4'b0000));
        step_clk();
        valid = 1'b0;
        step_check();
        chk("ff bypass lane2 valid", 32'(vld_w[2][2]), 32'(1));
        chk("ff bypass lane2 data", 32'(data_w[2][2]), 32'(8'hA4));
        step_clk();
        tick();
        tick();

        // Full lane 0 pops and pushes in the same slot-0 cycle
        rdy_in = 4'b0001;
        valid  = 1'b1;
        data   = 8'hB8;
        step_check();
        chk("fullpop lane_sel", 32'(sel_w[0]), 32'(4'b0001));
        chk("fullpop fill before", 32'(fill_a[0]), 32'(1));
        chk("fullpop old data", 32'(data_w[0][0]), 32'(8'hA0));
        step_clk();
        rdy_in = 4'b0000;
        valid  = 1'b0;
        step_check();
        chk("fullpop new data", 32'(data_w[0][0]), 32'(8'hB8));
        chk("fullpop fill after", 32'(fill_a[0]), 32'(1));
        step_clk();

        // Random traffic with occasional clear and reset
        for (int c = 0; c < 400; c++) begin
            valid  = ($urandom_range(0, 3) != 0);
            data   = byte_t'($urandom);
            rdy_in = 4'($urandom);
            clr    = ($urandom_range(0, 49) == 0);
            rst    = ($urandom_range(0, 96) == 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;
        valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
